// File: rtl/audio_pkg.sv
// Shared audio sample definitions used by the SPI front end, the sample FIFO and downstream consumers.
package audio_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port sample store: synchronous write, registered read with enable, no reset (maps to iCE40 EBR).
module sample_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO between spi_receiver and the sample consumer, with level and sticky error flags.
module sample_fifo #(
  parameter int DATA_W    = audio_pkg::DATA_W,
  parameter int DEPTH     = 256,
  parameter int AFULL_THR = 224
) (
  input  logic                       clk_12mhz,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       fifo_full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(AFULL_THR);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_next;
  logic [DATA_W-1:0] ram_q;
  logic              has_read;
  logic              push;
  logic              pop;

  // Acceptance uses the registered flags, i.e. the state at the start of the cycle.
  assign push = wr_en && !fifo_full;
  assign pop  = rd_en && !empty;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      fifo_full   <= 1'b0;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
      has_read    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level       <= level_next;
      empty       <= (level_next == '0);
      fifo_full   <= (level_next == LVL_FULL);
      almost_full <= (level_next >= LVL_AFULL);
      rd_valid    <= pop;
      has_read    <= has_read || pop;
      // A rejection in the same cycle as a clear keeps the flag set.
      overflow    <= (overflow  && !clr_flags) || (wr_en && fifo_full);
      underflow   <= (underflow && !clr_flags) || (rd_en && empty);
    end
  end

  sample_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk_12mhz),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // The RAM output has no reset, so present zero until the first pop since reset.
  assign rd_data = has_read ? ram_q : '0;

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: vector table, directed corner sequences and a queue-based reference model.
module tb_sample_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = 224;

  logic        clk_12mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        wr_en     = 1'b0;
  logic [15:0] wr_data   = '0;
  logic        rd_en     = 1'b0;
  logic        clr_flags = 1'b0;
  logic        fifo_full, almost_full, rd_valid, empty, overflow, underflow;
  logic [15:0] rd_data;
  logic [8:0]  level;

  int tests = 0;
  int fails = 0;

  logic [15:0] mq[$];
  logic        m_ovf, m_unf, m_vld;
  logic [15:0] m_data;

  typedef struct {
    bit          w;
    logic [15:0] d;
    bit          r;
    bit          c;
    int          lvl;
    bit          vld;
    logic [15:0] data;
    bit          unf;
  } vec_t;

  vec_t vecs[13];

  sample_fifo #(.DATA_W(16), .DEPTH(DEPTH), .AFULL_THR(AFULL)) dut (
    .clk_12mhz   (clk_12mhz),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_flags   (clr_flags)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_vld = 0; m_data = '0;
  endtask

  // Drive one cycle, let the edge happen, then advance the reference model.
  task automatic apply(input bit w, input logic [15:0] d, input bit r, input bit c);
    bit acc_w, acc_r;
    acc_w = w && (mq.size() < DEPTH);
    acc_r = r && (mq.size() > 0);
    wr_en = w; wr_data = d; rd_en = r; clr_flags = c;
    @(posedge clk_12mhz);
    #1;
    wr_en = 0; rd_en = 0; clr_flags = 0;
    if (acc_r) m_data = mq.pop_front();
    if (acc_w) mq.push_back(d);
    m_vld = acc_r;
    m_ovf = (m_ovf && !c) || (w && !acc_w);
    m_unf = (m_unf && !c) || (r && !acc_r);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"},    32'(level),       32'(mq.size()));
    chk({tag, ".empty"},    32'(empty),       32'(mq.size() == 0));
    chk({tag, ".full"},     32'(fifo_full),   32'(mq.size() == DEPTH));
    chk({tag, ".afull"},    32'(almost_full), 32'(mq.size() >= AFULL));
    chk({tag, ".rd_valid"}, 32'(rd_valid),    32'(m_vld));
    chk({tag, ".rd_data"},  32'(rd_data),     32'(m_data));
    chk({tag, ".overflow"}, 32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"},32'(underflow),   32'(m_unf));
  endtask

  task automatic step(input string tag, input bit w, input logic [15:0] d, input bit r, input bit c);
    apply(w, d, r, c);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_12mhz);
    rst_n = 0;
    repeat (2) @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    rst_n = 1;
    model_reset();
    #1;
  endtask

  initial begin
    model_reset();

    // Reset held with a push request pending.
    rst_n = 0; wr_en = 1; wr_data = 16'h5555;
    repeat (3) @(posedge clk_12mhz);
    #1;
    chk("rst.level",     32'(level),       0);
    chk("rst.empty",     32'(empty),       1);
    chk("rst.full",      32'(fifo_full),   0);
    chk("rst.afull",     32'(almost_full), 0);
    chk("rst.rd_valid",  32'(rd_valid),    0);
    chk("rst.rd_data",   32'(rd_data),     0);
    chk("rst.overflow",  32'(overflow),    0);
    chk("rst.underflow", 32'(underflow),   0);
    wr_en = 0;
    @(negedge clk_12mhz);
    rst_n = 1;
    #1;

    // Ordering and underflow/clear vectors, one row per cycle.
    vecs[0]  = '{1, 16'hBBAA, 0, 0, 1, 0, 16'h0000, 0};
    vecs[1]  = '{1, 16'h1234, 0, 0, 2, 0, 16'h0000, 0};
    vecs[2]  = '{1, 16'hFFFF, 0, 0, 3, 0, 16'h0000, 0};
    vecs[3]  = '{0, 16'h0000, 1, 0, 2, 1, 16'hBBAA, 0};
    vecs[4]  = '{0, 16'h0000, 1, 0, 1, 1, 16'h1234, 0};
    vecs[5]  = '{0, 16'h0000, 1, 0, 0, 1, 16'hFFFF, 0};
    vecs[6]  = '{0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0};
    vecs[7]  = '{0, 16'h0000, 1, 0, 0, 0, 16'hFFFF, 1};
    vecs[8]  = '{0, 16'h0000, 0, 1, 0, 0, 16'hFFFF, 0};
    vecs[9]  = '{0, 16'h0000, 1, 1, 0, 0, 16'hFFFF, 1};
    vecs[10] = '{0, 16'h0000, 0, 1, 0, 0, 16'hFFFF, 0};
    vecs[11] = '{1, 16'h0001, 1, 0, 1, 0, 16'hFFFF, 1};
    vecs[12] = '{0, 16'h0000, 1, 1, 0, 1, 16'h0001, 0};
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
      chk($sformatf("vec%0d.level", i),     32'(level),     32'(vecs[i].lvl));
      chk($sformatf("vec%0d.rd_valid", i),  32'(rd_valid),  32'(vecs[i].vld));
      chk($sformatf("vec%0d.rd_data", i),   32'(rd_data),   32'(vecs[i].data));
      chk($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].unf));
      chk($sformatf("vec%0d.empty", i),     32'(empty),     32'(vecs[i].lvl == 0));
    end

    // Fill, overflow, drain, then a second full cycle to wrap the pointers.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) step("fill", 1, 16'(i + pass * 16'h1000), 0, 0);
      chk("fill.full", 32'(fifo_full), 1);
      step("fill.extra", 1, 16'hDEAD, 0, 0);
      chk("fill.overflow", 32'(overflow), 1);
      for (int i = 0; i < DEPTH; i++) begin
        step("drain", 0, 16'h0, 1, 0);
        chk("drain.order", 32'(rd_data), 32'(16'(i + pass * 16'h1000)));
      end
      step("drain.clr", 0, 16'h0, 0, 1);
    end

    // Simultaneous push/pop at a mid level, then at full.
    do_reset();
    for (int i = 0; i < 100; i++) step("mid.fill", 1, 16'(16'h2000 + i), 0, 0);
    for (int i = 0; i < 50; i++) step("mid.both", 1, 16'(16'h3000 + i), 1, 0);
    chk("mid.level", 32'(level), 100);
    while (mq.size() < DEPTH) step("top.fill", 1, 16'h4444, 0, 0);
    step("full.both", 1, 16'hBEEF, 1, 0);
    chk("full.both.level", 32'(level), 255);
    chk("full.both.ovf",   32'(overflow), 1);

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    for (int i = 0; i < 37; i++) step("r37.fill", 1, 16'(16'h5000 + i), 0, 0);
    apply(0, 16'h0, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk("async.level",    32'(level),     0);
    chk("async.empty",    32'(empty),     1);
    chk("async.rd_valid", 32'(rd_valid),  0);
    chk("async.rd_data",  32'(rd_data),   0);
    chk("async.afull",    32'(almost_full), 0);
    @(negedge clk_12mhz);
    rst_n = 1;
    model_reset();
    #1;
    step("post.push", 1, 16'hC0DE, 0, 0);
    step("post.pop",  0, 16'h0, 1, 0);
    chk("post.data", 32'(rd_data), 32'h0000C0DE);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      bit w, r;
      phase = (i / 500) % 3;
      w = (phase == 0) ? ($urandom_range(0, 9) < 8) : (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
      r = (phase == 0) ? ($urandom_range(0, 9) < 2) : (phase == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1) == 1;
      step("rand", w, 16'($urandom), r, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
